// File: rtl/otter_cu_fsm_pkg.sv
// ----------------------------------------------------------------------------
// otter_cu_fsm_pkg
// Shared definitions for the OTTER multi-cycle control FSM: the state
// encoding (3-bit, matching the encoding the decoder expects) and the
// opcode / funct3 / full-instruction constants used to classify the
// instruction in EXEC.
// ----------------------------------------------------------------------------
package otter_cu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_INTRPT = 3'd4
    } cu_state_t;

    localparam logic [6:0] OPCODE_OP_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_SYS    = 7'b1110011;

    localparam logic [2:0]  FUNC_SYS_CSRRW  = 3'b001;
    localparam logic [31:0] PREFIX_SYS_MRET = 32'h30200073;

    // Opcodes that update both PC and a destination register in one EXEC cycle.
    function automatic logic is_single_cycle_wb(input logic [6:0] opcode);
        return (opcode == OPCODE_OP_REG) || (opcode == OPCODE_OP_IMM) ||
               (opcode == OPCODE_LUI)    || (opcode == OPCODE_AUIPC)  ||
               (opcode == OPCODE_JAL)    || (opcode == OPCODE_JALR);
    endfunction

endpackage

// File: rtl/otter_cu_fsm_intrpt_sync.sv
// ----------------------------------------------------------------------------
// otter_intrpt_sync
// Flop-chain synchronizer bringing the asynchronous external interrupt level
// into the core clock domain.
// Ports:
//   clk       core clock
//   rst       synchronous active-high reset, clears the chain
//   async_in  raw interrupt level
//   sync_out  synchronized level (SYNC_STAGES cycles of latency)
// ----------------------------------------------------------------------------
module otter_intrpt_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw level through the chain; only the last flop is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/otter_cu_fsm.sv
// ----------------------------------------------------------------------------
// otter_cu_fsm
// Multi-cycle control FSM of the OTTER core. Sequences INIT, FETCH, EXEC,
// WB and INTRPT, stalls on memory acknowledges and takes interrupts only
// when an instruction retires with mstatus.MIE set.
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   instrn                         current instruction (valid in EXEC/WB)
//   intrpt, mie                    async interrupt level, mstatus.MIE
//   imem_ack, dmem_ack             memory completion strobes
//   core_rst                       resets PC and CSRs
//   imem_rd_en, dmem_rd_en         fetch / load requests
//   dmem_w_en                      store request
//   pc_w_en, rfile_w_en, csr_w_en  architectural write enables
//   mret_exec                      MRET retiring
//   intrpt_taken                   trap entry (decoder selects mtvec)
// All outputs are combinational from state, instrn, the acks and rst.
// ----------------------------------------------------------------------------
module otter_cu_fsm
    import otter_cu_fsm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrn,
    input  logic        intrpt,
    input  logic        mie,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        core_rst,
    output logic        imem_rd_en,
    output logic        dmem_rd_en,
    output logic        dmem_w_en,
    output logic        pc_w_en,
    output logic        rfile_w_en,
    output logic        csr_w_en,
    output logic        mret_exec,
    output logic        intrpt_taken
);

    cu_state_t state;
    cu_state_t next_state;
    cu_state_t retire_state;
    logic      intrpt_sync;
    logic [6:0] opcode;
    logic [2:0] funct3;

    otter_intrpt_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_intrpt_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (intrpt),
        .sync_out (intrpt_sync)
    );

    assign opcode   = instrn[6:0];
    assign funct3   = instrn[14:12];
    assign core_rst = rst | (state == ST_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and enable decode. Every retiring path goes through
    // retire_state so the interrupt check is made only at instruction
    // boundaries and never aborts a load/store in flight.
    always_comb begin
        next_state   = state;
        retire_state = (intrpt_sync & mie) ? ST_INTRPT : ST_FETCH;
        imem_rd_en   = 1'b0;
        dmem_rd_en   = 1'b0;
        dmem_w_en    = 1'b0;
        pc_w_en      = 1'b0;
        rfile_w_en   = 1'b0;
        csr_w_en     = 1'b0;
        mret_exec    = 1'b0;
        intrpt_taken = 1'b0;

        case (state)
            ST_INIT: begin
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_rd_en = 1'b1;
                if (imem_ack) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_single_cycle_wb(opcode)) begin
                    pc_w_en    = 1'b1;
                    rfile_w_en = 1'b1;
                    next_state = retire_state;
                end else if (opcode == OPCODE_LOAD) begin
                    // A dmem_ack here is ignored: the load is only issued now.
                    dmem_rd_en = 1'b1;
                    next_state = ST_WB;
                end else if (opcode == OPCODE_STORE) begin
                    dmem_w_en = 1'b1;
                    if (dmem_ack) begin
                        pc_w_en    = 1'b1;
                        next_state = retire_state;
                    end
                end else if (opcode == OPCODE_SYS && instrn == PREFIX_SYS_MRET) begin
                    mret_exec  = 1'b1;
                    pc_w_en    = 1'b1;
                    next_state = retire_state;
                end else if (opcode == OPCODE_SYS && funct3 == FUNC_SYS_CSRRW) begin
                    csr_w_en   = 1'b1;
                    rfile_w_en = 1'b1;
                    pc_w_en    = 1'b1;
                    next_state = retire_state;
                end else begin
                    // Branches, other SYS encodings and unknown opcodes only advance PC.
                    pc_w_en    = 1'b1;
                    next_state = retire_state;
                end
            end
            ST_WB: begin
                dmem_rd_en = 1'b1;
                if (dmem_ack) begin
                    rfile_w_en = 1'b1;
                    pc_w_en    = 1'b1;
                    next_state = retire_state;
                end
            end
            ST_INTRPT: begin
                intrpt_taken = 1'b1;
                pc_w_en      = 1'b1;
                next_state   = ST_FETCH;
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase

        // Reset overrides everything, including a half-finished WB or store.
        if (rst) begin
            next_state   = ST_INIT;
            imem_rd_en   = 1'b0;
            dmem_rd_en   = 1'b0;
            dmem_w_en    = 1'b0;
            pc_w_en      = 1'b0;
            rfile_w_en   = 1'b0;
            csr_w_en     = 1'b0;
            mret_exec    = 1'b0;
            intrpt_taken = 1'b0;
        end
    end

`ifdef FORMAL
    always_comb begin
        assert (!(dmem_rd_en && dmem_w_en));
        assert (!intrpt_taken || state == ST_INTRPT);
        assert (!rst || next_state == ST_INIT);
    end
`endif

endmodule

// File: tb/tb_otter_cu_fsm.sv
// ----------------------------------------------------------------------------
// tb_otter_cu_fsm
// Self-checking bench for otter_cu_fsm. A driver walks instruction-level
// transactions (fetch wait, execute, memory wait, optional trap, optional
// reset abort) and pushes the expected output vector for every cycle into a
// queue; an independent monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_otter_cu_fsm;

    // Output vector bit weights:
    // {core_rst, imem_rd_en, dmem_rd_en, dmem_w_en, pc_w_en, rfile_w_en,
    //  csr_w_en, mret_exec, intrpt_taken}
    localparam logic [8:0] E_NONE = 9'h000;
    localparam logic [8:0] E_CORE = 9'h100;
    localparam logic [8:0] E_IMEM = 9'h080;
    localparam logic [8:0] E_DRD  = 9'h040;
    localparam logic [8:0] E_DWR  = 9'h020;
    localparam logic [8:0] E_PC   = 9'h010;
    localparam logic [8:0] E_RF   = 9'h008;
    localparam logic [8:0] E_CSR  = 9'h004;
    localparam logic [8:0] E_MRET = 9'h002;
    localparam logic [8:0] E_TRAP = 9'h001;

    localparam int K_ALU   = 0;
    localparam int K_PC    = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;
    localparam int K_CSR   = 4;
    localparam int K_MRET  = 5;

    localparam int SYNC_STAGES = 2;

    logic        clk;
    logic        rst;
    logic [31:0] instrn;
    logic        intrpt;
    logic        mie;
    logic        imem_ack;
    logic        dmem_ack;
    logic        core_rst;
    logic        imem_rd_en;
    logic        dmem_rd_en;
    logic        dmem_w_en;
    logic        pc_w_en;
    logic        rfile_w_en;
    logic        csr_w_en;
    logic        mret_exec;
    logic        intrpt_taken;

    logic [8:0] exp_q[$];
    string      name_q[$];

    int tests;
    int fails;

    logic       irq_lvl;
    logic       mie_lvl;
    bit         rand_irq;
    bit         noise;
    logic [SYNC_STAGES-1:0] irq_delay;

    otter_cu_fsm #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instrn       (instrn),
        .intrpt       (intrpt),
        .mie          (mie),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .core_rst     (core_rst),
        .imem_rd_en   (imem_rd_en),
        .dmem_rd_en   (dmem_rd_en),
        .dmem_w_en    (dmem_w_en),
        .pc_w_en      (pc_w_en),
        .rfile_w_en   (rfile_w_en),
        .csr_w_en     (csr_w_en),
        .mret_exec    (mret_exec),
        .intrpt_taken (intrpt_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction class derived directly from the ISA encoding rules.
    function automatic int classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return K_ALU;
            7'b1100011: return K_PC;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1110011: begin
                if (ins == 32'h30200073) return K_MRET;
                if (ins[14:12] == 3'b001) return K_CSR;
                return K_PC;
            end
            default: return K_PC;
        endcase
    endfunction

    function automatic logic nz();
        if (noise) return logic'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // One clock cycle of stimulus. The interrupt seen by the core is the raw
    // level delayed by SYNC_STAGES edges, cleared by reset; trap_ok reports
    // whether a retire in this cycle should take a trap.
    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic ia,
                                 input logic da, input logic [8:0] exp, input string name,
                                 output logic trap_ok);
        @(posedge clk);
        if (rst) irq_delay = '0;
        else     irq_delay = {irq_delay[SYNC_STAGES-2:0], intrpt};
        #1;
        if (rand_irq) begin
            if ($urandom_range(0, 7) == 0) irq_lvl = ~irq_lvl;
            if ($urandom_range(0, 3) == 0) mie_lvl = ~mie_lvl;
        end
        rst      = r;
        instrn   = ins;
        imem_ack = ia;
        dmem_ack = da;
        intrpt   = irq_lvl;
        mie      = mie_lvl;
        exp_q.push_back(exp);
        name_q.push_back(name);
        trap_ok = irq_delay[SYNC_STAGES-1] & mie_lvl & ~r;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {core_rst, imem_rd_en, dmem_rd_en, dmem_w_en, pc_w_en,
               rfile_w_en, csr_w_en, mret_exec, intrpt_taken};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic doReset(input int cycles);
        logic t;
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b1, $urandom, nz(), nz(), E_CORE, "reset", t);
        applyStimulus(1'b0, $urandom, nz(), nz(), E_CORE, "init", t);
    endtask

    // Full instruction: fetch with fwait stall cycles, execute, memory wait
    // of mwait cycles, then an INTRPT cycle if the retire cycle allows it.
    // abort_at >= 0 asserts reset in that memory-wait cycle instead.
    task automatic runInstr(input logic [31:0] ins, input int fwait, input int mwait,
                            input int abort_at);
        logic t;
        int   k;
        logic [31:0] fetch_bus;
        k = classify(ins);
        t = 1'b0;
        for (int i = 0; i <= fwait; i++) begin
            fetch_bus = noise ? $urandom : ins;
            applyStimulus(1'b0, fetch_bus, (i == fwait), nz(), E_IMEM, "fetch", t);
        end
        case (k)
            K_ALU:  applyStimulus(1'b0, ins, nz(), nz(), E_PC | E_RF, "exec_alu", t);
            K_PC:   applyStimulus(1'b0, ins, nz(), nz(), E_PC, "exec_pc_only", t);
            K_CSR:  applyStimulus(1'b0, ins, nz(), nz(), E_CSR | E_RF | E_PC, "exec_csrrw", t);
            K_MRET: applyStimulus(1'b0, ins, nz(), nz(), E_MRET | E_PC, "exec_mret", t);
            K_LOAD: begin
                applyStimulus(1'b0, ins, nz(), nz(), E_DRD, "exec_load", t);
                for (int j = 0; j <= mwait; j++) begin
                    if (j == abort_at) begin
                        doReset(1);
                        return;
                    end
                    applyStimulus(1'b0, ins, nz(), (j == mwait),
                                  E_DRD | ((j == mwait) ? (E_RF | E_PC) : E_NONE), "wb", t);
                end
            end
            default: begin
                for (int j = 0; j <= mwait; j++) begin
                    if (j == abort_at) begin
                        doReset(1);
                        return;
                    end
                    applyStimulus(1'b0, ins, nz(), (j == mwait),
                                  E_DWR | ((j == mwait) ? E_PC : E_NONE), "store", t);
                end
            end
        endcase
        if (t) applyStimulus(1'b0, $urandom, nz(), nz(), E_TRAP | E_PC, "intrpt", t);
    endtask

    // Monitor: compares one expected vector per cycle, away from the rising edge.
    initial begin
        logic [8:0] e;
        string      n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(n, e);
            end
        end
    end

    // Driver: directed scenarios first, then randomized instruction stream.
    initial begin
        logic [6:0]  op_tab [10];
        logic [31:0] r;
        logic [31:0] ins;
        logic [6:0]  op;
        int sel, fw, mw, ab;

        op_tab = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                   7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011};
        tests = 0;
        fails = 0;
        rst = 1'b1; instrn = '0; intrpt = 1'b0; mie = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        irq_lvl = 1'b0; mie_lvl = 1'b0; rand_irq = 1'b0; noise = 1'b0;
        irq_delay = '0;

        doReset(3);
        runInstr(32'h00500093, 1, 0, -1);
        runInstr(32'h0000A103, 0, 3, -1);
        runInstr(32'h0020A023, 0, 1, -1);
        irq_lvl = 1'b1; mie_lvl = 1'b1;
        runInstr(32'h00500093, 1, 0, -1);
        mie_lvl = 1'b0;
        runInstr(32'h00500093, 1, 0, -1);
        irq_lvl = 1'b0;
        runInstr(32'h30200073, 0, 0, -1);
        runInstr(32'h0000A103, 0, 3, 1);

        noise = 1'b1;
        rand_irq = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r   = $urandom;
            sel = $urandom_range(0, 12);
            if (sel < 10) op = op_tab[sel];
            else          op = r[6:0];
            ins = {r[31:7], op};
            if (sel == 12) ins = 32'h30200073;
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, mw) : -1;
            runInstr(ins, fw, mw, ab);
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
